// File: rtl/rip_decode_queue.sv
// rip_decode_queue -- RV32I decode stage fronted by a DEPTH-entry instruction queue.
//
// Fetch words are written into a small circular queue. The queue head is decoded
// combinationally, and that result is captured into a registered output bundle
// when the output register is free or is being consumed this cycle.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The source holds valid and payload stable
// until the transfer. f_ready depends only on queue fullness, never on a
// same-cycle pop, so a full queue never accepts a word (no pass-through).
// dec_* are held stable while dec_valid && !dec_ready.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   flush                       drop queue contents and the output bundle
//   f_valid/f_ready/f_pc/f_inst fetch-side handshake and payload
//   hd_rs1_num/hd_rs2_num       source registers of the queue head (0 if empty/unused)
//   dec_valid/dec_ready         execute-side handshake
//   dec_pc, dec_op, dec_rs1/rs2/rd, dec_csr, dec_zimm, dec_imm
//   dec_acc_mem/dec_upd_reg/dec_upd_pc/dec_illegal   control flags
//   occ                         current queue occupancy
//
// Build option: define RIP_DECODE_M_EXT_EN to decode the M extension
// (MUL..REMU as ops 48-55); otherwise those encodings are illegal.
module rip_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int OP_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [PC_W-1:0]          f_pc,
  input  logic [31:0]              f_inst,
  output logic [4:0]               hd_rs1_num,
  output logic [4:0]               hd_rs2_num,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [PC_W-1:0]          dec_pc,
  output logic [OP_W-1:0]          dec_op,
  output logic [4:0]               dec_rs1,
  output logic [4:0]               dec_rs2,
  output logic [4:0]               dec_rd,
  output logic [11:0]              dec_csr,
  output logic [4:0]               dec_zimm,
  output logic [31:0]              dec_imm,
  output logic                     dec_acc_mem,
  output logic                     dec_upd_reg,
  output logic                     dec_upd_pc,
  output logic                     dec_illegal,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);

  // Output register state; dec_valid is this state made visible.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [11:0]     csr;
    logic [4:0]      zimm;
    logic [31:0]     imm;
    logic            acc_mem;
    logic            upd_reg;
    logic            upd_pc;
    logic            illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t        d;
    logic [5:0]  op;
    logic        use_rd, use_rs1, use_rs2, is_csr, is_zimm, is_mem, is_jmp;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    d = '0;
    op = '0;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    is_csr = 1'b0; is_zimm = 1'b0; is_mem = 1'b0; is_jmp = 1'b0;
    imm = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'b0110111: begin op = 6'd1; use_rd = 1'b1; imm = {ins[31:12], 12'b0}; end
      7'b0010111: begin op = 6'd2; use_rd = 1'b1; imm = {ins[31:12], 12'b0}; end
      7'b1101111: begin
        op = 6'd3; use_rd = 1'b1; is_jmp = 1'b1;
        imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111: begin
        if (f3 == 3'd0) op = 6'd4;
        use_rd = 1'b1; use_rs1 = 1'b1; is_jmp = 1'b1;
        imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b1100011: begin
        case (f3)
          3'd0: op = 6'd5;
          3'd1: op = 6'd6;
          3'd4: op = 6'd7;
          3'd5: op = 6'd8;
          3'd6: op = 6'd9;
          3'd7: op = 6'd10;
          default: op = '0;
        endcase
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_jmp = 1'b1;
        imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0000011: begin
        case (f3)
          3'd0: op = 6'd11;
          3'd1: op = 6'd12;
          3'd2: op = 6'd13;
          3'd4: op = 6'd14;
          3'd5: op = 6'd15;
          default: op = '0;
        endcase
        use_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1;
        imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        case (f3)
          3'd0: op = 6'd16;
          3'd1: op = 6'd17;
          3'd2: op = 6'd18;
          default: op = '0;
        endcase
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1;
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b0010011: begin
        case (f3)
          3'd0: op = 6'd19;
          3'd2: op = 6'd20;
          3'd3: op = 6'd21;
          3'd4: op = 6'd22;
          3'd6: op = 6'd23;
          3'd7: op = 6'd24;
          3'd1: op = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
          default: op = (f7 == 7'b0000000) ? 6'd26 :
                        (f7 == 7'b0100000) ? 6'd27 : 6'd0;
        endcase
        use_rd = 1'b1; use_rs1 = 1'b1;
        // Shifts carry an unsigned shamt rather than a sign-extended immediate.
        if (f3 == 3'd1 || f3 == 3'd5) imm = {27'b0, ins[24:20]};
        else                          imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: op = 6'd28;
            3'd1: op = 6'd30;
            3'd2: op = 6'd31;
            3'd3: op = 6'd32;
            3'd4: op = 6'd33;
            3'd5: op = 6'd34;
            3'd6: op = 6'd36;
            default: op = 6'd37;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0)      op = 6'd29;
          else if (f3 == 3'd5) op = 6'd35;
        end
`ifdef RIP_DECODE_M_EXT_EN
        else if (f7 == 7'b0000001) begin
          op = 6'd48 + {3'b0, f3};
        end
`endif
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0001111: begin
        if (f3 == 3'd0)      op = 6'd38;
        else if (f3 == 3'd1) op = 6'd39;
      end
      7'b1110011: begin
        if (f3 == 3'd0) begin
          // Only the exact ECALL/EBREAK words are accepted here.
          if (ins == 32'h0000_0073)      begin op = 6'd40; is_jmp = 1'b1; end
          else if (ins == 32'h0010_0073) begin op = 6'd41; is_jmp = 1'b1; end
        end else begin
          case (f3)
            3'd1: op = 6'd42;
            3'd2: op = 6'd43;
            3'd3: op = 6'd44;
            3'd5: op = 6'd45;
            3'd6: op = 6'd46;
            3'd7: op = 6'd47;
            default: op = '0;
          endcase
          use_rd = 1'b1; is_csr = 1'b1;
          use_rs1 = !f3[2];
          is_zimm = f3[2];
        end
      end
      default: op = '0;
    endcase

    if (op == '0) begin
      // Illegal word: redirect the pipeline to the trap handler.
      d.illegal = 1'b1;
      d.upd_pc  = 1'b1;
    end else begin
      d.op      = OP_W'(op);
      d.rd      = use_rd  ? ins[11:7]  : 5'd0;
      d.rs1     = use_rs1 ? ins[19:15] : 5'd0;
      d.rs2     = use_rs2 ? ins[24:20] : 5'd0;
      d.csr     = is_csr  ? ins[31:20] : 12'd0;
      d.zimm    = is_zimm ? ins[19:15] : 5'd0;
      d.imm     = imm;
      d.acc_mem = is_mem;
      d.upd_pc  = is_jmp;
      d.upd_reg = (d.rd != 5'd0);
    end
    return d;
  endfunction

  // Queue storage; pointers carry an extra wrap bit to tell full from empty.
  logic [PC_W-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [0:0]      state_q, state_d;
  dec_t            dec_q, dec_d;
  logic [PC_W-1:0] dec_pc_q, dec_pc_d;

  logic  empty, full, push, load;
  dec_t  head_dec;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign f_ready  = !full;
  assign push     = f_valid && f_ready;
  assign load     = !empty && ((state_q == ST_EMPTY) || dec_ready);
  assign head_dec = decode(inst_mem_q[rd_ptr_q[AW-1:0]]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    dec_d    = dec_q;
    dec_pc_d = dec_pc_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = ST_EMPTY;
      dec_d    = '0;
      dec_pc_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (load) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        state_d  = ST_HOLD;
        dec_d    = head_dec;
        dec_pc_d = pc_mem_q[rd_ptr_q[AW-1:0]];
      end else if (state_q == ST_HOLD && dec_ready) begin
        state_d  = ST_EMPTY;
        dec_d    = '0;
        dec_pc_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= ST_EMPTY;
      dec_q    <= '0;
      dec_pc_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      dec_q    <= dec_d;
      dec_pc_q <= dec_pc_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[wr_ptr_q[AW-1:0]]   <= f_pc;
      inst_mem_q[wr_ptr_q[AW-1:0]] <= f_inst;
    end
  end

  assign hd_rs1_num  = empty ? 5'd0 : head_dec.rs1;
  assign hd_rs2_num  = empty ? 5'd0 : head_dec.rs2;
  assign dec_valid   = (state_q == ST_HOLD);
  assign dec_pc      = dec_pc_q;
  assign dec_op      = dec_q.op;
  assign dec_rs1     = dec_q.rs1;
  assign dec_rs2     = dec_q.rs2;
  assign dec_rd      = dec_q.rd;
  assign dec_csr     = dec_q.csr;
  assign dec_zimm    = dec_q.zimm;
  assign dec_imm     = dec_q.imm;
  assign dec_acc_mem = dec_q.acc_mem;
  assign dec_upd_reg = dec_q.upd_reg;
  assign dec_upd_pc  = dec_q.upd_pc;
  assign dec_illegal = dec_q.illegal;
  assign occ         = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_rip_decode_queue.sv
// Testbench for rip_decode_queue: directed scenarios plus randomized traffic,
// compared every cycle against a table-driven RV32I reference model.
module tb_rip_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int OP_W  = 6;
  localparam int N_ALL = 55;
`ifdef RIP_DECODE_M_EXT_EN
  localparam int N_OPS = 55;
`else
  localparam int N_OPS = 47;
`endif

  localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4,
                 F_U = 5, F_J = 6, F_C = 7, F_Z = 8, F_N = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, flush, f_valid, f_ready, dec_ready, dec_valid;
  logic [PC_W-1:0]   f_pc, dec_pc;
  logic [31:0]       f_inst, dec_imm;
  logic [4:0]        hd_rs1_num, hd_rs2_num, dec_rs1, dec_rs2, dec_rd, dec_zimm;
  logic [OP_W-1:0]   dec_op;
  logic [11:0]       dec_csr;
  logic              dec_acc_mem, dec_upd_reg, dec_upd_pc, dec_illegal;
  logic [$clog2(DEPTH):0] occ;

  rip_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_inst(f_inst),
    .hd_rs1_num(hd_rs1_num), .hd_rs2_num(hd_rs2_num),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_op(dec_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_csr(dec_csr),
    .dec_zimm(dec_zimm), .dec_imm(dec_imm), .dec_acc_mem(dec_acc_mem),
    .dec_upd_reg(dec_upd_reg), .dec_upd_pc(dec_upd_pc), .dec_illegal(dec_illegal),
    .occ(occ)
  );

  // ---------------- reference instruction table ----------------
  // Entry i decodes to op i+1 when (inst & mask) == match.
  logic [31:0] t_mask [N_ALL] = '{
    32'h7F, 32'h7F, 32'h7F, 32'h707F,
    32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
    32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
    32'h707F, 32'h707F, 32'h707F,
    32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h707F, 32'h707F, 32'hFFFFFFFF, 32'hFFFFFFFF,
    32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F
  };
  logic [31:0] t_match [N_ALL] = '{
    32'h37, 32'h17, 32'h6F, 32'h67,
    32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
    32'h03, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
    32'h23, 32'h1023, 32'h2023,
    32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
    32'h1013, 32'h5013, 32'h40005013,
    32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
    32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033,
    32'h0F, 32'h100F, 32'h73, 32'h00100073,
    32'h1073, 32'h2073, 32'h3073, 32'h5073, 32'h6073, 32'h7073,
    32'h02000033, 32'h02001033, 32'h02002033, 32'h02003033,
    32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033
  };
  int t_fmt [N_ALL] = '{
    F_U, F_U, F_J, F_I,
    F_B, F_B, F_B, F_B, F_B, F_B,
    F_I, F_I, F_I, F_I, F_I,
    F_S, F_S, F_S,
    F_I, F_I, F_I, F_I, F_I, F_I,
    F_SH, F_SH, F_SH,
    F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R,
    F_N, F_N, F_N, F_N,
    F_C, F_C, F_C, F_Z, F_Z, F_Z,
    F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R
  };

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr;
    logic [4:0]  zimm;
    logic [31:0] imm;
    logic        acc_mem, upd_reg, upd_pc, ill;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t r;
    int   hit;
    int   v;
    r = '0;
    hit = -1;
    for (int i = 0; i < N_OPS; i++)
      if (hit < 0 && (ins & t_mask[i]) == t_match[i]) hit = i;
    if (hit < 0) begin
      r.ill = 1'b1;
      r.upd_pc = 1'b1;
      return r;
    end
    r.op = 6'(hit + 1);
    case (t_fmt[hit])
      F_R:  begin r.rd = ins[11:7]; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; end
      F_I:  begin r.rd = ins[11:7]; r.rs1 = ins[19:15]; r.imm = 32'($signed(ins) >>> 20); end
      F_SH: begin r.rd = ins[11:7]; r.rs1 = ins[19:15]; r.imm = (ins >> 20) & 32'h1F; end
      F_S:  begin
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
        r.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | ((ins >> 7) & 32'h1F);
      end
      F_B:  begin
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
        v = ins[31] ? -4096 : 0;
        v += int'(ins[7]) * 2048;
        v += int'((ins >> 25) & 32'h3F) * 32;
        v += int'((ins >> 8) & 32'hF) * 2;
        r.imm = 32'(v);
      end
      F_U:  begin r.rd = ins[11:7]; r.imm = ins & 32'hFFFFF000; end
      F_J:  begin
        r.rd = ins[11:7];
        v = ins[31] ? -(1 << 20) : 0;
        v += int'((ins >> 12) & 32'hFF) * 4096;
        v += int'(ins[20]) * 2048;
        v += int'((ins >> 21) & 32'h3FF) * 2;
        r.imm = 32'(v);
      end
      F_C:  begin r.rd = ins[11:7]; r.rs1 = ins[19:15]; r.csr = ins[31:20]; end
      F_Z:  begin r.rd = ins[11:7]; r.zimm = ins[19:15]; r.csr = ins[31:20]; end
      default: ;
    endcase
    r.upd_reg = (r.rd != 5'd0);
    r.acc_mem = (r.op >= 6'd11 && r.op <= 6'd18);
    r.upd_pc  = (r.op >= 6'd3 && r.op <= 6'd10) || r.op == 6'd40 || r.op == 6'd41;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];          // {pc, inst} words waiting in the queue
  logic        m_valid;
  logic [63:0] m_word;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit can_push;
    if (!rst_n || flush) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_word  = '0;
    end else begin
      can_push = f_valid && (exp_q.size() < DEPTH);
      if (exp_q.size() > 0 && (!m_valid || dec_ready)) begin
        m_word  = exp_q.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && dec_ready) begin
        m_valid = 1'b0;
        m_word  = '0;
      end
      if (can_push) exp_q.push_back({f_pc, f_inst});
    end
  endtask

  task automatic compare_all();
    ref_t e, h;
    e = m_valid ? ref_decode(m_word[31:0]) : '0;
    h = (exp_q.size() > 0) ? ref_decode(exp_q[0][31:0]) : '0;
    check("dec_valid", 64'(dec_valid), 64'(m_valid));
    check("occ", 64'(occ), 64'(exp_q.size()));
    check("f_ready", 64'(f_ready), 64'(exp_q.size() < DEPTH));
    check("dec_pc", 64'(dec_pc), m_valid ? 64'(m_word[63:32]) : 64'd0);
    check("dec_op", 64'(dec_op), 64'(e.op));
    check("dec_regs", 64'({dec_rs1, dec_rs2, dec_rd}), 64'({e.rs1, e.rs2, e.rd}));
    check("dec_csr_zimm", 64'({dec_csr, dec_zimm}), 64'({e.csr, e.zimm}));
    check("dec_imm", 64'(dec_imm), 64'(e.imm));
    check("dec_flags", 64'({dec_acc_mem, dec_upd_reg, dec_upd_pc, dec_illegal}),
          64'({e.acc_mem, e.upd_reg, e.upd_pc, e.ill}));
    check("hd_rs", 64'({hd_rs1_num, hd_rs2_num}), 64'({h.rs1, h.rs2}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drain();
    f_valid   = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || m_valid); i++) tick();
    check("drain_done", 64'(dec_valid), 64'd0);
  endtask

  task automatic push_and_decode(input logic [31:0] pc, input logic [31:0] inst);
    drain();
    f_valid = 1'b1;
    f_pc    = pc;
    f_inst  = inst;
    tick();
    f_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_inst();
    int idx;
    if ($urandom_range(0, 9) == 0) return $urandom;
    idx = $urandom_range(0, N_ALL - 1);
    return ($urandom & ~t_mask[idx]) | t_match[idx];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; f_valid = 1'b0; dec_ready = 1'b0;
    f_pc = '0; f_inst = '0;
    m_valid = 1'b0; m_word = '0;
    tick();
    tick();
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_f_ready", 64'(f_ready), 64'd1);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_op", 64'(dec_op), 64'd0);
    rst_n = 1'b1;

    // Latency: accepted at edge E, visible after edge E+1.
    f_valid = 1'b1; f_pc = 32'h100; f_inst = 32'h00500093; dec_ready = 1'b1;
    tick();
    check("addi_not_yet", 64'(dec_valid), 64'd0);
    f_valid = 1'b0;
    tick();
    check("addi_valid", 64'(dec_valid), 64'd1);
    check("addi_op", 64'(dec_op), 64'd19);
    check("addi_rd", 64'(dec_rd), 64'd1);
    check("addi_imm", 64'(dec_imm), 64'd5);
    check("addi_pc", 64'(dec_pc), 64'h100);

    // Back-pressure: fill the queue while the addi bundle is held.
    dec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      f_valid = 1'b1;
      f_pc    = 32'h200 + 32'(4 * i);
      f_inst  = {12'(i + 1), 5'd0, 3'd0, 5'(i + 2), 7'b0010011};
      tick();
    end
    check("full_occ", 64'(occ), 64'(DEPTH));
    check("full_f_ready", 64'(f_ready), 64'd0);
    check("held_op", 64'(dec_op), 64'd19);
    check("held_pc", 64'(dec_pc), 64'h100);
    f_pc = 32'hDEAD; f_inst = 32'h00000013;
    tick();                                   // dropped: queue full
    f_valid = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("drain_order_pc", 64'(dec_pc), 64'(32'h200 + 32'(4 * i)));
    end
    tick();
    check("drain_empty", 64'(dec_valid), 64'd0);

    push_and_decode(32'h400, 32'h40105093);
    check("srai_op", 64'(dec_op), 64'd27);
    check("srai_imm", 64'(dec_imm), 64'd1);
    push_and_decode(32'h404, 32'hFE000EE3);   // beq x0,x0,-4
    check("beq_op", 64'(dec_op), 64'd5);
    check("beq_imm", 64'(dec_imm), 64'hFFFFFFFC);
    check("beq_upd_pc", 64'(dec_upd_pc), 64'd1);
    push_and_decode(32'h408, 32'h342022F3);
    check("csrrs_op", 64'(dec_op), 64'd43);
    check("csrrs_csr", 64'(dec_csr), 64'h342);
    check("csrrs_rd", 64'(dec_rd), 64'd5);
    push_and_decode(32'h40C, 32'h3420D073);
    check("csrrwi_op", 64'(dec_op), 64'd45);
    check("csrrwi_zimm", 64'(dec_zimm), 64'd1);
    check("csrrwi_rd", 64'(dec_rd), 64'd0);
    check("csrrwi_upd_reg", 64'(dec_upd_reg), 64'd0);

    // Flush with a same-cycle push: the pushed word must vanish.
    drain();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_valid = 1'b1; f_pc = 32'h500 + 32'(4 * i); f_inst = rand_inst();
      tick();
    end
    check("pre_flush_occ", 64'(occ), 64'd3);
    flush = 1'b1; f_valid = 1'b1; f_pc = 32'h5F0; f_inst = 32'h00100093;
    tick();
    check("flush_occ", 64'(occ), 64'd0);
    check("flush_dec_valid", 64'(dec_valid), 64'd0);
    flush = 1'b0; f_valid = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("flush_word_absent", 64'(dec_valid), 64'd0);

    push_and_decode(32'h600, 32'h02208033);
`ifdef RIP_DECODE_M_EXT_EN
    check("mul_op", 64'(dec_op), 64'd48);
    check("mul_illegal", 64'(dec_illegal), 64'd0);
`else
    check("mul_op", 64'(dec_op), 64'd0);
    check("mul_illegal", 64'(dec_illegal), 64'd1);
`endif

    // Randomized traffic with back-pressure, flushes and occasional reset.
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      f_valid   = ($urandom_range(0, 2) != 0);
      dec_ready = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      f_pc      = $urandom;
      f_inst    = rand_inst();
      tick();
    end
    rst_n = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
